// File: rtl/clock_pkg.sv
// clock_pkg: alarm state type and time field widths shared by the clock blocks
package clock_pkg;
    typedef enum logic [1:0] {IDLE, RING, SNOOZE} state_t;
    localparam int HOUR_W = 5;
    localparam int MIN_W  = 6;
    localparam int SEC_W  = 6;
endpackage

// File: rtl/alarm_ctrl_if.sv
// alarm_ctrl_if: time, alarm setting, button and buzzer signals around the alarm sequencer
interface alarm_ctrl_if;
    import clock_pkg::*;
    logic              sec_tick;
    logic [HOUR_W-1:0] cur_hour;
    logic [MIN_W-1:0]  cur_min;
    logic [SEC_W-1:0]  cur_sec;
    logic [HOUR_W-1:0] alarm_hour;
    logic [MIN_W-1:0]  alarm_min;
    logic              alarm_on;
    logic              stop_btn;
    logic              snooze_btn;
    logic              buzz_en;
    logic              ringing;
    logic              snoozing;
    modport master (
        output sec_tick, cur_hour, cur_min, cur_sec, alarm_hour, alarm_min,
        output alarm_on, stop_btn, snooze_btn,
        input  buzz_en, ringing, snoozing
    );
    modport slave (
        input  sec_tick, cur_hour, cur_min, cur_sec, alarm_hour, alarm_min,
        input  alarm_on, stop_btn, snooze_btn,
        output buzz_en, ringing, snoozing
    );
endinterface

// File: rtl/alarm_ctrl_cadence_gen.sv
// cadence_gen: beep on/off cadence counter; `on` is the value for the cycle after this edge
module cadence_gen #(
    parameter int CYC_PER_100MS = 500,
    parameter int ON_UNITS      = 2,
    parameter int OFF_UNITS     = 2
) (
    input  logic CLK,
    input  logic RSTN,
    input  logic run,
    output logic on
);
    localparam int PERIOD = (ON_UNITS + OFF_UNITS) * CYC_PER_100MS;
    localparam int ON_CYC = ON_UNITS * CYC_PER_100MS;
    localparam int CW     = $clog2(PERIOD);
    logic [CW-1:0] cnt_q, cnt_d;
    always_comb cnt_d = !run ? '0 : (cnt_q == CW'(PERIOD - 1)) ? '0 : cnt_q + 1'b1;
    assign on = int'(cnt_d) < ON_CYC;
    always_ff @(posedge CLK or negedge RSTN) begin
        if (!RSTN) cnt_q <= '0;
        else       cnt_q <= cnt_d;
    end
endmodule

// File: rtl/alarm_ctrl.sv
// alarm_ctrl: alarm match detection, ring/snooze sequencing and cadence-gated buzzer enable
module alarm_ctrl
    import clock_pkg::*;
#(
    parameter int CYC_PER_100MS = 500,
    parameter int ON_UNITS      = 2,
    parameter int OFF_UNITS     = 2,
    parameter int RING_SEC      = 60,
    parameter int SNOOZE_SEC    = 300,
    parameter int MAX_SNOOZE    = 3
) (
    input  logic         CLK,
    input  logic         RSTN,
    alarm_ctrl_if.slave  bus
);
    localparam int RW = $clog2(RING_SEC + 1);
    localparam int SW = $clog2(SNOOZE_SEC + 1);
    localparam int NW = $clog2(MAX_SNOOZE + 1);
    state_t        state_q, state_d;
    logic [RW-1:0] ring_cnt_q, ring_cnt_d;
    logic [SW-1:0] snz_cnt_q, snz_cnt_d;
    logic [NW-1:0] snooze_cnt_q, snooze_cnt_d;
    logic          match, match_q, trigger;
    logic          buzz_en_q, ringing_q, snoozing_q;
    logic          cad_run, cad_on;
    assign match   = bus.alarm_on && bus.cur_hour == bus.alarm_hour &&
                     bus.cur_min == bus.alarm_min && bus.cur_sec == '0;
    assign trigger = match && !match_q;
    always_comb begin
        state_d      = state_q;
        ring_cnt_d   = ring_cnt_q;
        snz_cnt_d    = snz_cnt_q;
        snooze_cnt_d = snooze_cnt_q;
        if (!bus.alarm_on) begin
            state_d = IDLE;
        end else if (state_q == IDLE) begin
            if (trigger) begin
                state_d      = RING;
                snooze_cnt_d = '0;
                ring_cnt_d   = RW'(RING_SEC);
            end
        end else if (bus.stop_btn) begin
            state_d = IDLE;
        end else if (state_q == RING) begin
            if (bus.snooze_btn && snooze_cnt_q < NW'(MAX_SNOOZE)) begin
                state_d      = SNOOZE;
                snooze_cnt_d = snooze_cnt_q + 1'b1;
                snz_cnt_d    = SW'(SNOOZE_SEC);
            end else if (bus.sec_tick && ring_cnt_q != '0) begin
                ring_cnt_d = ring_cnt_q - 1'b1;
                if (ring_cnt_q == RW'(1)) state_d = IDLE;
            end
        end else if (bus.sec_tick && snz_cnt_q != '0) begin
            snz_cnt_d = snz_cnt_q - 1'b1;
            if (snz_cnt_q == SW'(1)) begin
                state_d    = RING;
                ring_cnt_d = RW'(RING_SEC);
            end
        end
    end
    // Cadence only advances while staying in RING, so every RING entry starts at phase 0
    assign cad_run = state_q == RING && state_d == RING;
    cadence_gen #(
        .CYC_PER_100MS(CYC_PER_100MS),
        .ON_UNITS     (ON_UNITS),
        .OFF_UNITS    (OFF_UNITS)
    ) u_cadence (
        .CLK (CLK),
        .RSTN(RSTN),
        .run (cad_run),
        .on  (cad_on)
    );
    always_ff @(posedge CLK or negedge RSTN) begin
        if (!RSTN) begin
            state_q      <= IDLE;
            match_q      <= 1'b0;
            ring_cnt_q   <= '0;
            snz_cnt_q    <= '0;
            snooze_cnt_q <= '0;
            buzz_en_q    <= 1'b0;
            ringing_q    <= 1'b0;
            snoozing_q   <= 1'b0;
        end else begin
            state_q      <= state_d;
            match_q      <= match;
            ring_cnt_q   <= ring_cnt_d;
            snz_cnt_q    <= snz_cnt_d;
            snooze_cnt_q <= snooze_cnt_d;
            buzz_en_q    <= state_d == RING && cad_on;
            ringing_q    <= state_d == RING;
            snoozing_q   <= state_d == SNOOZE;
        end
    end
    assign bus.buzz_en  = buzz_en_q;
    assign bus.ringing  = ringing_q;
    assign bus.snoozing = snoozing_q;
endmodule

// File: tb/tb_alarm_ctrl.sv
// tb_alarm_ctrl: scoreboard bench for the alarm sequencer at default cadence and timeout settings
module tb_alarm_ctrl;
    logic CLK = 1'b0;
    logic RSTN = 1'b0;
    int checks = 0;
    int errors = 0;
    typedef struct {
        string      tag;
        logic [2:0] exp;
    } exp_t;
    exp_t sb[$];
    alarm_ctrl_if bus();
    alarm_ctrl dut (.CLK(CLK), .RSTN(RSTN), .bus(bus));
    always #5 CLK = ~CLK;
    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got {ringing,snoozing,buzz_en}=%03b expected %03b", tag, got[2:0], exp[2:0]);
        end
    endtask
    task automatic expect_out(input string tag, input logic r, input logic s, input logic b);
        sb.push_back('{tag, {r, s, b}});
    endtask
    task automatic compare_out();
        exp_t e;
        e = sb.pop_front();
        chk(e.tag, 32'({bus.ringing, bus.snoozing, bus.buzz_en}), 32'(e.exp));
    endtask
    task automatic cyc(input int n);
        repeat (n) begin
            @(posedge CLK);
            #1;
        end
    endtask
    task automatic cyc_chk(input string tag, input logic r, input logic s, input logic b);
        expect_out(tag, r, s, b);
        cyc(1);
        compare_out();
    endtask
    task automatic tick(input int n);
        repeat (n) begin
            bus.sec_tick = 1'b1;
            cyc(1);
            bus.sec_tick = 1'b0;
            cyc(1);
        end
    endtask
    task automatic set_time(input logic [4:0] h, input logic [5:0] m, input logic [5:0] s);
        bus.cur_hour = h;
        bus.cur_min  = m;
        bus.cur_sec  = s;
    endtask
    task automatic trigger(input string tag);
        set_time(5'd7, 6'd30, 6'd1);
        cyc(2);
        set_time(5'd7, 6'd30, 6'd0);
        cyc_chk(tag, 1'b1, 1'b0, 1'b1);
    endtask
    task automatic snooze_cycle(input string tag);
        bus.snooze_btn = 1'b1;
        cyc_chk({tag, "_enter"}, 1'b0, 1'b1, 1'b0);
        bus.snooze_btn = 1'b0;
        tick(299);
        cyc_chk({tag, "_wait"}, 1'b0, 1'b1, 1'b0);
        bus.sec_tick = 1'b1;
        cyc_chk({tag, "_rering"}, 1'b1, 1'b0, 1'b1);
        bus.sec_tick = 1'b0;
    endtask
    initial begin
        bus.sec_tick   = 1'b0;
        bus.stop_btn   = 1'b0;
        bus.snooze_btn = 1'b0;
        bus.alarm_on   = 1'b1;
        bus.alarm_hour = 5'd7;
        bus.alarm_min  = 6'd30;
        set_time(5'd7, 6'd29, 6'd59);
        #12;
        expect_out("reset", 1'b0, 1'b0, 1'b0);
        compare_out();
        @(posedge CLK);
        #1;
        RSTN = 1'b1;
        cyc_chk("pre_match", 1'b0, 1'b0, 1'b0);
        // Ring, cadence boundaries, then auto-stop after 60 ticks
        set_time(5'd7, 6'd30, 6'd0);
        cyc_chk("trigger", 1'b1, 1'b0, 1'b1);
        cyc(998);
        cyc_chk("cad_on_last", 1'b1, 1'b0, 1'b1);
        cyc_chk("cad_off_first", 1'b1, 1'b0, 1'b0);
        cyc(998);
        cyc_chk("cad_off_last", 1'b1, 1'b0, 1'b0);
        cyc_chk("cad_wrap", 1'b1, 1'b0, 1'b1);
        tick(59);
        cyc_chk("ring_tick59", 1'b1, 1'b0, 1'b1);
        bus.sec_tick = 1'b1;
        cyc_chk("auto_stop", 1'b0, 1'b0, 1'b0);
        bus.sec_tick = 1'b0;
        cyc(5);
        cyc_chk("no_retrigger", 1'b0, 1'b0, 1'b0);
        // Three snoozes, fourth ignored; re-entry reloads ring_cnt despite coincident tick
        trigger("trigger2");
        snooze_cycle("snz1");
        cyc(998);
        cyc_chk("rering_cad_on", 1'b1, 1'b0, 1'b1);
        cyc_chk("rering_cad_off", 1'b1, 1'b0, 1'b0);
        snooze_cycle("snz2");
        snooze_cycle("snz3");
        bus.snooze_btn = 1'b1;
        cyc_chk("snz4_ignored", 1'b1, 1'b0, 1'b1);
        bus.snooze_btn = 1'b0;
        tick(59);
        cyc_chk("rering_tick59", 1'b1, 1'b0, 1'b1);
        bus.sec_tick = 1'b1;
        cyc_chk("auto_stop2", 1'b0, 1'b0, 1'b0);
        bus.sec_tick = 1'b0;
        // Stop and snooze together
        trigger("trigger3");
        cyc(3);
        bus.stop_btn   = 1'b1;
        bus.snooze_btn = 1'b1;
        cyc_chk("both_btn", 1'b0, 1'b0, 1'b0);
        bus.stop_btn   = 1'b0;
        bus.snooze_btn = 1'b0;
        cyc_chk("both_btn_after", 1'b0, 1'b0, 1'b0);
        // Disarm during snooze
        trigger("trigger4");
        bus.snooze_btn = 1'b1;
        cyc_chk("disarm_snz", 1'b0, 1'b1, 1'b0);
        bus.snooze_btn = 1'b0;
        bus.alarm_on = 1'b0;
        cyc_chk("disarm", 1'b0, 1'b0, 1'b0);
        tick(350);
        cyc_chk("disarm_quiet", 1'b0, 1'b0, 1'b0);
        set_time(5'd7, 6'd31, 6'd0);
        bus.alarm_on = 1'b1;
        cyc(2);
        // Reset during the buzzing phase
        trigger("trigger5");
        cyc(10);
        RSTN = 1'b0;
        #2;
        expect_out("reset_mid", 1'b0, 1'b0, 1'b0);
        compare_out();
        set_time(5'd7, 6'd30, 6'd5);
        cyc(2);
        RSTN = 1'b1;
        tick(5);
        cyc_chk("post_reset_idle", 1'b0, 1'b0, 1'b0);
        trigger("trigger6");
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
